// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, programmable almost flags,
// sticky overflow/underflow, synchronous flush and registered or FWFT read data.
module sync_fifo_ctrl #(
    parameter int DEPTH      = 1024,
    parameter int DW         = 8,
    parameter int CW         = $clog2(DEPTH + 1),
    parameter int AFULL_THR  = DEPTH - 1,
    parameter int AEMPTY_THR = 1,
    parameter int FWFT       = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wen,
    input  logic [DW-1:0] wdata,
    input  logic          ren,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          wr_acc, rd_acc;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AFULL_THR));
    assign almost_empty = (count <= CW'(AEMPTY_THR));

    assign wr_acc = wen && !full && !clr;
    assign rd_acc = ren && !empty && !clr;

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            if (rd_acc) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wen && full)  overflow  <= 1'b1;
            if (ren && empty) underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[rptr];
        end else begin : g_reg
            logic [DW-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      rdata_q <= '0;
                else if (clr)    rdata_q <= '0;
                else if (rd_acc) rdata_q <= mem[rptr];
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule
